// File: rtl/freq_gate_ctrl.sv
// Purpose : gated-window frequency counter; counts rising edges of sigin over a fixed sysclk window.
// Latency : 3 sysclk from sigin pin to edge strobe; result (freq/ovf/valid) one cycle after LATCH.
// Backpres: none; start is a level sampled only in IDLE, valid is a single-cycle pulse with no handshake.
//
// Ports:
//   sysclk  - system clock, the only clock in the block
//   rst_n   - asynchronous active-low reset
//   start   - request a single measurement (only looked at while IDLE)
//   auto    - continuous back-to-back measurements while high
//   sigin   - signal under test, asynchronous to sysclk
//   freq    - rising-edge count latched at the end of the last completed gate window
//   valid   - one-cycle pulse coinciding with each freq/ovf update
//   ovf     - edge counter saturated during the last completed gate window
//   gate    - high while the gate window is open
//   busy    - high in every state except IDLE
module freq_gate_ctrl #(
  parameter int GATE_CYCLES = 50000000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int CNT_W       = 24
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             auto,
  input  logic             sigin,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             gate,
  output logic             busy
);

  // Timer is shared by GATE and HOLD, so it is sized for the longer of the two.
  localparam int MAX_CYC = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_GATE  = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  // sync1/sync2 resolve metastability; sync3 is the history flop. The edge
  // strobe itself is registered so the pin-to-strobe latency is a fixed 3 cycles.
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic edge_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sigin;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM and datapath state
  // ---------------------------------------------------------------------------
  state_t             state_q,   state_d;
  logic [TMR_W-1:0]   timer_q,   timer_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic               ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0]   freq_q,    freq_d;
  logic               ovf_q,     ovf_d;
  logic               valid_q,   valid_d;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      ovf_int_q <= 1'b0;
      freq_q    <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      ovf_int_q <= ovf_int_d;
      freq_q    <= freq_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    ovf_int_d = ovf_int_q;
    freq_d    = freq_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start || auto) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        timer_d   = '0;
        count_d   = '0;
        ovf_int_d = 1'b0;
        state_d   = S_GATE;
      end

      S_GATE: begin
        timer_d = timer_q + 1'b1;
        // Saturate rather than wrap: a wrapped count would look like a
        // plausible low frequency, whereas all-ones plus ovf is unambiguous.
        if (edge_q) begin
          if (&count_q) begin
            ovf_int_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        if (timer_q == GATE_LAST) begin
          timer_d = '0;
          state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        // The edge counted on the final GATE cycle is already in count_q here.
        freq_d  = count_q;
        ovf_d   = ovf_int_q;
        valid_d = 1'b1;
        timer_d = '0;
        state_d = S_HOLD;
      end

      S_HOLD: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          // auto is sampled only at the end of HOLD, so dropping it mid-run
          // lets the current measurement finish before returning to IDLE.
          state_d = auto ? S_CLEAR : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // gate/busy decode straight from the state register so an asynchronous
  // reset drops them in the same cycle without waiting for a clock edge.
  assign gate  = (state_q == S_GATE);
  assign busy  = (state_q != S_IDLE);
  assign freq  = freq_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;

endmodule

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000, gate window length in sysclk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000, post-latch hold time in sysclk cycles.
REQ-003 SHALL have parameter CNT_W, default 24, width of the edge counter and result.
REQ-004 SHALL have port sysclk  in  1  system clock, 50 MHz; the only clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  request one measurement; sampled only in IDLE.
REQ-007 SHALL have port auto  in  1  1 = continuous back-to-back measurements.
REQ-008 SHALL have port sigin  in  1  signal under test, asynchronous to sysclk.
REQ-009 SHALL have port freq  out  CNT_W  latched rising-edge count of the last completed gate.
REQ-010 SHALL have port valid  out  1  one-cycle pulse when freq updates.
REQ-011 SHALL have port ovf  out  1  counter saturated during the last completed gate; updates with freq.
REQ-012 SHALL have port gate  out  1  high while the gate window is open.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL pass sigin through a 2-flop synchronizer plus 1 history flop; rising edge = sync2 & ~sync3, registered for 3 cycles of latency from the pin.
REQ-015 SHALL implement a 5-state FSM: IDLE, CLEAR, GATE, LATCH, HOLD.
REQ-016 IDLE: when start=1 or auto=1, go to CLEAR next cycle; otherwise stay.
REQ-017 CLEAR: lasts 1 cycle, sets count=0, ovf_int=0 and timer=0, then goes to GATE.
REQ-018 GATE: gate=1 and timer increments each cycle; exit to LATCH after exactly GATE_CYCLES cycles, when timer==GATE_CYCLES-1.
REQ-019 GATE: count increments by 1 on each detected edge, including an edge on the final GATE cycle.
REQ-020 GATE saturation: count stays at 2^CNT_W-1 and ovf_int is set when an edge arrives at all-ones; no wrap-around.
REQ-021 Edges detected in IDLE, CLEAR, LATCH or HOLD SHALL be discarded.
REQ-022 LATCH: lasts 1 cycle, sets freq=count, ovf=ovf_int and valid=1 (registered; valid is high only in the cycle after LATCH), then goes to HOLD.
REQ-023 HOLD: lasts HOLD_CYCLES cycles (timer restarts at 0), then goes to CLEAR if auto=1, else to IDLE.
REQ-024 start asserted in any state other than IDLE SHALL be ignored; start is not queued.
REQ-025 In auto mode, SHALL produce one valid pulse every GATE_CYCLES+HOLD_CYCLES+2 cycles.
REQ-026 Deasserting auto mid-measurement SHALL let the current measurement complete, then return to IDLE.
REQ-027 Timer width SHALL be clog2(max(GATE_CYCLES,HOLD_CYCLES)).
REQ-028 freq and ovf SHALL hold their value between LATCH events.

Reset
REQ-029 rst_n=0 SHALL immediately force, regardless of state: state=IDLE; timer, count and ovf_int =0; synchronizer flops =0; freq=0, valid=0, ovf=0, gate=0, busy=0.
REQ-030 A measurement in progress when reset asserts SHALL be abandoned with no valid pulse.
REQ-031 After release, the first measurement SHALL need a fresh start, or auto=1.

Verification (GATE_CYCLES=100, HOLD_CYCLES=10, CNT_W=8 unless noted)
REQ-032 sigin toggles every 5 cycles, start pulsed once -> one valid pulse; freq=10, ovf=0, gate high for exactly 100 cycles.
REQ-033 sigin held 0, start pulsed -> freq=0, ovf=0, valid pulse, then busy=0 after HOLD.
REQ-034 CNT_W=5, sigin toggles every cycle (50 edges), start pulsed -> freq=31, ovf=1.
REQ-035 auto=1, sigin period 20 cycles -> valid pulses exactly 112 cycles apart, each with freq=5; auto dropped mid-GATE -> one more result, then IDLE.
REQ-036 rst_n pulled low mid-GATE -> outputs 0 in the same cycle, no valid pulse; new start after release -> correct freq.
REQ-037 start re-pulsed during GATE and HOLD -> ignored; exactly one valid pulse per start accepted in IDLE.
